// File: rtl/imem_resp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_resp_pkg : core widths, NOP encoding and address helpers (rev 1.0)
// ----------------------------------------------------------------------------
package imem_resp_pkg;

  localparam int ADDR_LEN = 32;
  localparam int ISA_LEN  = 32;
  localparam logic [ISA_LEN-1:0] NOP_ENC = 32'h0000_0013;

  typedef logic [ADDR_LEN-3:0] word_addr_t;
  typedef logic [ISA_LEN-1:0]  inst_t;

  function automatic word_addr_t word_of(input logic [ADDR_LEN-1:0] byte_addr);
    return byte_addr[ADDR_LEN-1:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_pf_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_pf_buf : one-entry next-line prefetch buffer for imem_resp (rev 1.0)
// ----------------------------------------------------------------------------
module imem_pf_buf
  import imem_resp_pkg::*;
#(
  parameter int    WAIT_CYCLES = 2,
  parameter inst_t NOP_INST    = NOP_ENC
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       flush,
  input  logic       arm,
  input  logic       drop,
  input  logic       issue,
  input  word_addr_t issue_addr,
  input  logic       promote,
  input  inst_t      mem_rdata,
  output logic       pend,
  output word_addr_t pf_addr,
  output inst_t      pf_data,
  output logic       pf_valid,
  output logic       inflight
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             discard;
  logic             done;

  assign done = inflight && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pend     <= 1'b0;
      pf_addr  <= '0;
      pf_data  <= NOP_INST;
      pf_valid <= 1'b0;
      inflight <= 1'b0;
      cnt      <= '0;
      discard  <= 1'b0;
    end else begin
      if (arm)
        pend <= 1'b1;
      else if (issue || drop)
        pend <= 1'b0;

      if (issue) begin
        pf_addr  <= issue_addr;
        pf_valid <= 1'b0;
        inflight <= 1'b1;
        cnt      <= '0;
        discard  <= 1'b0;
      end else if (inflight) begin
        // A flushed prefetch still occupies the SRAM; only its data is dropped.
        if (done) begin
          inflight <= 1'b0;
          if (!discard && !flush) begin
            pf_data  <= mem_rdata;
            pf_valid <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (flush)
          discard <= 1'b1;
      end

      if (flush || promote)
        pf_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_resp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_resp : fixed-latency instruction SRAM fetch responder; optional
//             next-line prefetch under IMEM_PREFETCH_EN (rev 1.0)
// ----------------------------------------------------------------------------
module imem_resp
  import imem_resp_pkg::*;
#(
  parameter int    WAIT_CYCLES = 2,
  parameter inst_t NOP_INST    = NOP_ENC
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                req_i,
  input  logic [ADDR_LEN-1:0] addr_i,
  input  logic                flush,
  output logic [ISA_LEN-1:0]  rd_data_o,
  output logic                busy_,
  output logic                mem_en_o,
  output logic [ADDR_LEN-3:0] mem_addr_o,
  input  logic [ISA_LEN-1:0]  mem_rdata_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_VALID  = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  word_addr_t       addr_q;
  inst_t            data_q;

  word_addr_t word;
  logic       req, cnt_last, can_miss, hit, miss_want, mem_issue;
  logic       pf_hit, pf_issue, pf_inflight;
  word_addr_t pf_addr, pf_next;
  inst_t      pf_data;

  // Gating with rst_ forces reset-valued outputs the instant reset asserts.
  assign word      = word_of(addr_i);
  assign req       = req_i & rst_;
  assign cnt_last  = (cnt_q == CNT_LAST);
  assign can_miss  = (state_q == S_IDLE) || (state_q == S_VALID);
  assign hit       = req && (state_q == S_VALID) && (word == addr_q);
  assign miss_want = req && can_miss && !hit && !pf_hit;
  assign mem_issue = miss_want && !flush && !pf_inflight;

`ifdef IMEM_PREFETCH_EN
  logic pf_valid, pf_pend, pf_arm;

  assign pf_next  = addr_q + word_addr_t'(1);
  assign pf_hit   = req && can_miss && !hit && !flush && pf_valid && (word == pf_addr);
  assign pf_issue = rst_ && (state_q == S_VALID) && pf_pend && !miss_want && !pf_hit
                    && !flush && !pf_inflight;
  assign pf_arm   = (state_d == S_VALID) && ((state_q != S_VALID) || pf_hit);

  imem_pf_buf #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .NOP_INST    (NOP_INST)
  ) u_pf_buf (
    .clk        (clk),
    .rst_       (rst_),
    .flush      (flush),
    .arm        (pf_arm),
    .drop       (state_d != S_VALID),
    .issue      (pf_issue),
    .issue_addr (pf_next),
    .promote    (pf_hit),
    .mem_rdata  (mem_rdata_i),
    .pend       (pf_pend),
    .pf_addr    (pf_addr),
    .pf_data    (pf_data),
    .pf_valid   (pf_valid),
    .inflight   (pf_inflight)
  );
`else
  assign pf_next     = '0;
  assign pf_hit      = 1'b0;
  assign pf_issue    = 1'b0;
  assign pf_inflight = 1'b0;
  assign pf_addr     = '0;
  assign pf_data     = NOP_INST;
`endif

  assign busy_      = !req || hit || pf_hit;
  assign rd_data_o  = hit ? data_q : (pf_hit ? pf_data : NOP_INST);
  assign mem_en_o   = mem_issue || pf_issue;
  assign mem_addr_o = mem_issue ? word : (pf_issue ? pf_next : '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mem_issue)   state_d = S_ACCESS;
        else if (pf_hit) state_d = S_VALID;
      end
      S_ACCESS: begin
        if (flush || (req && (word != addr_q))) state_d = S_DRAIN;
        else if (cnt_last)                       state_d = S_VALID;
      end
      S_VALID: begin
        if (flush)          state_d = S_IDLE;
        else if (mem_issue) state_d = S_ACCESS;
      end
      default: begin
        if (cnt_last) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= NOP_INST;
    end else begin
      state_q <= state_d;

      if (mem_issue)
        cnt_q <= '0;
      else if (((state_q == S_ACCESS) || (state_q == S_DRAIN)) && !cnt_last)
        cnt_q <= cnt_q + 1'b1;

      if (mem_issue)
        addr_q <= word;
      else if (pf_hit)
        addr_q <= pf_addr;

      if ((state_q == S_ACCESS) && (state_d == S_VALID))
        data_q <= mem_rdata_i;
      else if ((state_q == S_VALID) && flush)
        data_q <= NOP_INST;
      else if (pf_hit)
        data_q <= pf_data;
    end
  end

endmodule
`default_nettype wire
